// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, issues word fetches and queues responses in order.
// Optional FETCH_PERF_CNT_EN adds perf_fetched / perf_dropped counters.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  input  logic        id_ready
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_dropped
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [CNT_W-1:0] cnt_t;

  logic [31:0]      fetch_pc;
  logic [31:0]      q_pc    [DEPTH];
  logic [31:0]      q_instr [DEPTH];
  logic [DEPTH-1:0] q_filled;
  ptr_t             head;
  ptr_t             tail;
  ptr_t             fill_ptr;
  cnt_t             alloc;
  cnt_t             unfilled;
  cnt_t             drop_cnt;

  logic             issue;
  logic             pop;
  logic             resp_drop;
  logic             resp_fill;
  cnt_t             drop_next;

  always_comb begin
    issue       = !reset && !redirect && (alloc != cnt_t'(DEPTH));
    imem_req    = issue;
    imem_addr   = fetch_pc;
    instr_valid = !reset && !redirect && (alloc != '0) && q_filled[head];
    pc          = q_pc[head];
    instr       = q_instr[head];
    pop         = instr_valid && id_ready;
    // a response landing in a redirect cycle belongs to a flushed fetch
    resp_drop   = imem_rvalid && (redirect || (drop_cnt != '0));
    resp_fill   = imem_rvalid && !redirect && !reset && (drop_cnt == '0);
    drop_next   = drop_cnt + unfilled - cnt_t'(imem_rvalid);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC & ~32'h3;
      head     <= '0;
      tail     <= '0;
      fill_ptr <= '0;
      alloc    <= '0;
      unfilled <= '0;
      drop_cnt <= '0;
      q_filled <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_pc[i]    <= '0;
        q_instr[i] <= '0;
      end
    end else if (redirect) begin
      fetch_pc <= redirect_pc & ~32'h3;
      head     <= '0;
      tail     <= '0;
      fill_ptr <= '0;
      alloc    <= '0;
      unfilled <= '0;
      q_filled <= '0;
      drop_cnt <= drop_next;
    end else begin
      if (issue) begin
        q_pc[tail]     <= fetch_pc;
        q_filled[tail] <= 1'b0;
        tail           <= tail + ptr_t'(1);
        fetch_pc       <= fetch_pc + 32'd4;
      end
      // fill_ptr always trails tail over allocated-but-empty entries, so it never hits tail here
      if (resp_fill) begin
        q_instr[fill_ptr]  <= imem_rdata;
        q_filled[fill_ptr] <= 1'b1;
        fill_ptr           <= fill_ptr + ptr_t'(1);
      end
      if (resp_drop) begin
        drop_cnt <= drop_cnt - cnt_t'(1);
      end
      if (pop) begin
        head <= head + ptr_t'(1);
      end
      alloc    <= alloc + cnt_t'(issue) - cnt_t'(pop);
      unfilled <= unfilled + cnt_t'(issue) - cnt_t'(resp_fill);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && resp_fill) begin
      assert (unfilled != '0);
    end
  end

`ifdef FETCH_PERF_CNT_EN
  cnt_t filled_cnt;

  always_comb begin
    filled_cnt = alloc - unfilled;
  end

  // every word that never reaches decode is counted once: either as a dropped response
  // or as a filled entry flushed by a redirect
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_dropped <= '0;
    end else begin
      perf_fetched <= perf_fetched + 32'(pop);
      perf_dropped <= perf_dropped + 32'(resp_drop)
                      + (redirect ? 32'(filled_cnt) : 32'd0);
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed vector table, redirect corner sequences and
// randomized traffic against a queue-based reference model with an in-order memory model.
module tb_if_fetch;

  localparam logic [31:0] RPC   = 32'h0000_0100;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        id_ready = 1'b0;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_dropped;
`endif

  always #5 clk = ~clk;

  if_fetch #(.RESET_PC(RPC), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr_valid (instr_valid),
    .instr       (instr),
    .pc          (pc),
    .id_ready    (id_ready)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched(perf_fetched),
    .perf_dropped(perf_dropped)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
    bit          filled;
  } ent_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  typedef struct {
    bit          rdy;
    bit          exp_req;
    logic [31:0] exp_addr;
    bit          exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  ent_t        mq[$];
  req_t        pend[$];
  logic [31:0] m_fetch_pc;
  int          m_drop;
  int          m_fetched;
  int          m_dropped;
  int          cyc = 0;
  int          last_due = 0;
  int          lat = 1;
  int          errors = 0;
  int          checks = 0;

  logic        s_req;
  logic        s_valid;
  logic [31:0] s_addr;
  logic [31:0] s_pc;
  logic [31:0] s_instr;

  vec_t        tbl[16];

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    pend.delete();
    m_fetch_pc = RPC;
    m_drop     = 0;
    m_fetched  = 0;
    m_dropped  = 0;
    last_due   = cyc;
  endtask

  // One clock cycle: drive inputs, compare DUT against the model, advance the model.
  task automatic step(input bit rst, input bit rd, input logic [31:0] rpc, input bit rdy);
    bit          rv;
    logic [31:0] rdat;
    bit          e_req;
    bit          e_valid;
    @(posedge clk);
    #1;
    reset       = rst;
    redirect    = rd;
    redirect_pc = rpc;
    id_ready    = rdy;
    rv   = 1'b0;
    rdat = $urandom;
    if (!rst && pend.size() > 0 && pend[0].due <= cyc) begin
      rv   = 1'b1;
      rdat = memfn(pend[0].addr);
      void'(pend.pop_front());
    end
    imem_rvalid = rv;
    imem_rdata  = rdat;
    #3;
    s_req   = imem_req;
    s_addr  = imem_addr;
    s_valid = instr_valid;
    s_pc    = pc;
    s_instr = instr;

    if (rst) begin
      e_req   = 1'b0;
      e_valid = 1'b0;
    end else begin
      e_req   = !rd && (mq.size() < DEPTH);
      e_valid = !rd && (mq.size() > 0) && mq[0].filled;
    end
    chk("imem_req", {31'b0, s_req}, {31'b0, e_req});
    chk("instr_valid", {31'b0, s_valid}, {31'b0, e_valid});
    if (e_req && s_req) chk("imem_addr", s_addr, m_fetch_pc);
    if (e_valid && s_valid) begin
      chk("pc", s_pc, mq[0].pc);
      chk("instr", s_instr, mq[0].ins);
    end

    if (rst) begin
      model_reset();
    end else if (rd) begin
      int unf = 0;
      int fil = 0;
      foreach (mq[i]) begin
        if (mq[i].filled) fil++;
        else unf++;
      end
      m_dropped  += fil + int'(rv);
      m_drop      = m_drop + unf - int'(rv);
      mq.delete();
      m_fetch_pc  = rpc & ~32'h3;
    end else begin
      if (e_valid && rdy) begin
        void'(mq.pop_front());
        m_fetched++;
      end
      if (rv) begin
        if (m_drop > 0) begin
          m_drop--;
          m_dropped++;
        end else begin
          int idx = -1;
          for (int i = 0; i < mq.size(); i++) begin
            if (!mq[i].filled && idx < 0) idx = i;
          end
          chk("fill_target", {31'b0, idx >= 0}, 32'd1);
          if (idx >= 0) begin
            mq[idx].filled = 1'b1;
            mq[idx].ins    = rdat;
          end
        end
      end
      if (e_req) begin
        req_t r;
        ent_t e;
        e.pc     = m_fetch_pc;
        e.ins    = '0;
        e.filled = 1'b0;
        mq.push_back(e);
        r.addr = m_fetch_pc;
        r.due  = cyc + lat;
        if (r.due <= last_due) r.due = last_due + 1;
        last_due = r.due;
        pend.push_back(r);
        m_fetch_pc += 32'd4;
      end
    end
    cyc++;
  endtask

  initial begin
    int found;
    int k_found;

    tbl[0]  = '{1'b0, 1'b1, 32'h100, 1'b0, 32'h000};
    tbl[1]  = '{1'b0, 1'b1, 32'h104, 1'b0, 32'h000};
    tbl[2]  = '{1'b0, 1'b1, 32'h108, 1'b1, 32'h100};
    tbl[3]  = '{1'b0, 1'b1, 32'h10c, 1'b1, 32'h100};
    tbl[4]  = '{1'b0, 1'b0, 32'h000, 1'b1, 32'h100};
    tbl[5]  = '{1'b0, 1'b0, 32'h000, 1'b1, 32'h100};
    tbl[6]  = '{1'b0, 1'b0, 32'h000, 1'b1, 32'h100};
    tbl[7]  = '{1'b0, 1'b0, 32'h000, 1'b1, 32'h100};
    tbl[8]  = '{1'b0, 1'b0, 32'h000, 1'b1, 32'h100};
    tbl[9]  = '{1'b0, 1'b0, 32'h000, 1'b1, 32'h100};
    tbl[10] = '{1'b1, 1'b0, 32'h000, 1'b1, 32'h100};
    tbl[11] = '{1'b1, 1'b1, 32'h110, 1'b1, 32'h104};
    tbl[12] = '{1'b1, 1'b1, 32'h114, 1'b1, 32'h108};
    tbl[13] = '{1'b1, 1'b1, 32'h118, 1'b1, 32'h10c};
    tbl[14] = '{1'b1, 1'b1, 32'h11c, 1'b1, 32'h110};
    tbl[15] = '{1'b1, 1'b1, 32'h120, 1'b1, 32'h114};

    model_reset();

    // reset: outputs quiet, then table of stall / release with a latency-1 memory
    lat = 1;
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    chk("reset_req", {31'b0, s_req}, 32'd0);
    chk("reset_valid", {31'b0, s_valid}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, '0, tbl[i].rdy);
      chk($sformatf("tbl%0d_req", i), {31'b0, s_req}, {31'b0, tbl[i].exp_req});
      if (tbl[i].exp_req) chk($sformatf("tbl%0d_addr", i), s_addr, tbl[i].exp_addr);
      chk($sformatf("tbl%0d_valid", i), {31'b0, s_valid}, {31'b0, tbl[i].exp_valid});
      if (tbl[i].exp_valid) begin
        chk($sformatf("tbl%0d_pc", i), s_pc, tbl[i].exp_pc);
        chk($sformatf("tbl%0d_instr", i), s_instr, memfn(tbl[i].exp_pc));
      end
    end

    // latency-3 memory, redirect to 0x2003 with two fetches in flight
    step(1'b1, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1);
    lat = 3;
    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b1, 32'h2003, 1'b1);
    chk("seqB_redir_req", {31'b0, s_req}, 32'd0);
    chk("seqB_redir_valid", {31'b0, s_valid}, 32'd0);
    step(1'b0, 1'b0, '0, 1'b1);
    chk("seqB_new_req", {31'b0, s_req}, 32'd1);
    chk("seqB_new_addr", s_addr, 32'h2000);
    found   = 0;
    k_found = -1;
    for (int k = 0; k < 10 && found == 0; k++) begin
      step(1'b0, 1'b0, '0, 1'b1);
      if (s_valid) begin
        found   = 1;
        k_found = k;
      end
    end
    chk("seqB_found", found, 32'd1);
    if (found != 0) begin
      chk("seqB_first_pc", s_pc, 32'h2000);
      chk("seqB_first_lat", k_found, 32'd3);
    end

    // redirect coinciding with imem_rvalid, instr_valid and id_ready
    step(1'b1, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1);
    lat = 1;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0, 1'b1);
    chk("seqC_pre_valid", {31'b0, s_valid}, 32'd1);
    step(1'b0, 1'b1, 32'h3000, 1'b1);
    chk("seqC_rvalid_driven", {31'b0, imem_rvalid}, 32'd1);
    chk("seqC_redir_valid", {31'b0, s_valid}, 32'd0);
    chk("seqC_redir_req", {31'b0, s_req}, 32'd0);
    step(1'b0, 1'b0, '0, 1'b1);
    chk("seqC_req", {31'b0, s_req}, 32'd1);
    chk("seqC_addr", s_addr, 32'h3000);
    step(1'b0, 1'b0, '0, 1'b1);
    chk("seqC_gap_valid", {31'b0, s_valid}, 32'd0);
    step(1'b0, 1'b0, '0, 1'b1);
    chk("seqC_valid", {31'b0, s_valid}, 32'd1);
    chk("seqC_pc", s_pc, 32'h3000);

    // randomized traffic, including back-to-back redirects and a mid-run reset
    for (int i = 0; i < 1500; i++) begin
      bit rst_r;
      bit rd_r;
      lat   = int'($urandom_range(1, 3));
      rst_r = (i >= 700 && i < 702);
      rd_r  = ($urandom % 12) == 0;
      step(rst_r, rd_r, $urandom, ($urandom % 4) != 0);
    end

`ifdef FETCH_PERF_CNT_EN
    @(posedge clk);
    #1;
    chk("perf_fetched", perf_fetched, m_fetched);
    chk("perf_dropped", perf_dropped, m_dropped);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
